// File: rtl/mac_pkg.sv
// Shared parameters and FSM state encoding for the MAC accumulator.
package mac_pkg;

    localparam int WIDTH_DEF = 12;
    localparam int ACC_W_DEF = 32;
    localparam int LEN_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/sat_add.sv
// Signed saturating adder: accumulator plus sign-extended product, clamped to ACC_W bits.
module sat_add #(
    parameter int IN_W  = 24,
    parameter int ACC_W = 32
) (
    input  logic [ACC_W-1:0] a,
    input  logic [IN_W-1:0]  b,
    output logic [ACC_W-1:0] sum,
    output logic             clamp
);

    logic [ACC_W:0] wide;

    always_comb begin
        wide  = {a[ACC_W-1], a} + {{(ACC_W + 1 - IN_W){b[IN_W-1]}}, b};
        clamp = 1'b0;
        sum   = wide[ACC_W-1:0];
        // Top two bits disagree only when the true sum left the ACC_W signed range.
        if (wide[ACC_W] != wide[ACC_W-1]) begin
            clamp = 1'b1;
            sum   = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/mac_accum.sv
// Dot-product accumulator: sums len signed Booth products with saturation and
// presents the result on a valid/ready output port.
module mac_accum
    import mac_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [LEN_W-1:0]   len,
    input  logic [2*WIDTH-1:0] prod,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [ACC_W-1:0]   acc_out,
    output logic               ovf,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic [1:0]         dbg_state
);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;

    logic [ACC_W-1:0] sum;
    logic             clamp;
    logic             xfer;

    sat_add #(
        .IN_W  (2 * WIDTH),
        .ACC_W (ACC_W)
    ) u_sat_add (
        .a     (acc_q),
        .b     (prod),
        .sum   (sum),
        .clamp (clamp)
    );

    // Handshakes: a beat moves only on a cycle where valid && ready are both high;
    // the producer holds its data stable until that cycle.
    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign acc_out   = acc_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;
    assign xfer      = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    if (len == '0) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d   = len;
                        state_d = ACC;
                    end
                end
            end
            ACC: begin
                if (xfer) begin
                    acc_d = sum;
                    ovf_d = ovf_q | clamp;
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // start is deliberately not looked at here, even on the exit cycle.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mac_accum.sv
// Bench for mac_accum: a 32-bit and a 24-bit accumulator driven by the same vectors,
// results checked against hand-computed values queued at stimulus time.
module tb_mac_accum;

    localparam int WIDTH   = 12;
    localparam int ACC_W   = 32;
    localparam int ACC_W24 = 24;
    localparam int LEN_W   = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [LEN_W-1:0]   len;
    logic [2*WIDTH-1:0] prod;
    logic               in_valid;
    logic               out_ready;

    logic               in_ready, ovf, out_valid, busy;
    logic [ACC_W-1:0]   acc_out;
    logic [1:0]         dbg_state;

    logic               in_ready24, ovf24, out_valid24, busy24;
    logic [ACC_W24-1:0] acc_out24;
    logic [1:0]         dbg_state24;

    int checks   = 0;
    int failures = 0;

    logic [ACC_W:0]   exp_q[$];
    logic [ACC_W24:0] exp24_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    mac_accum #(.WIDTH(WIDTH), .ACC_W(ACC_W), .LEN_W(LEN_W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .prod      (prod),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .acc_out   (acc_out),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    mac_accum #(.WIDTH(WIDTH), .ACC_W(ACC_W24), .LEN_W(LEN_W)) u_dut24 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .prod      (prod),
        .in_valid  (in_valid),
        .in_ready  (in_ready24),
        .acc_out   (acc_out24),
        .ovf       (ovf24),
        .out_valid (out_valid24),
        .out_ready (out_ready),
        .busy      (busy24),
        .dbg_state (dbg_state24)
    );

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL result32 unexpected output acc=%0h ovf=%0b", acc_out, ovf);
            end else begin
                chk("result32", {ovf, acc_out}, exp_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid24 === 1'b1 && out_ready === 1'b1) begin
            if (exp24_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL result24 unexpected output acc=%0h ovf=%0b", acc_out24, ovf24);
            end else begin
                chk("result24", {ovf24, acc_out24}, exp24_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_result(input logic [ACC_W-1:0] a32, input logic o32,
                                 input logic [ACC_W24-1:0] a24, input logic o24);
        exp_q.push_back({o32, a32});
        exp24_q.push_back({o24, a24});
    endtask

    task automatic do_start(input int n);
        start = 1'b1;
        len   = n[LEN_W-1:0];
        tick();
        start = 1'b0;
    endtask

    task automatic send_prod(input int p);
        in_valid = 1'b1;
        prod     = p[2*WIDTH-1:0];
        tick();
        in_valid = 1'b0;
    endtask

    task automatic set_prod(input int p);
        prod = p[2*WIDTH-1:0];
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = '0;
        prod      = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        #12;
        chk("reset_acc", acc_out, 0);
        chk("reset_state", dbg_state, 0);
        chk("reset_flags", {ovf, out_valid, in_ready, busy}, 0);
        chk("reset_flags24", {ovf24, out_valid24, in_ready24, busy24}, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // 100 - 50 + 7, in_valid held high; result 4 edges after start
        expect_result(32'd57, 1'b0, 24'd57, 1'b0);
        do_start(3);
        chk("acc3_busy_ready", {busy, in_ready}, 2'b11);
        in_valid = 1'b1;
        set_prod(100);
        tick();
        chk("acc3_early_valid", out_valid, 0);
        set_prod(-50);
        tick();
        chk("acc3_partial", acc_out, 32'd50);
        set_prod(7);
        tick();
        in_valid = 1'b0;
        chk("acc3_latency", out_valid, 1);
        chk("acc3_in_ready_done", in_ready, 0);
        chk("acc3_value", acc_out, 32'd57);
        tick();
        chk("acc3_idle", {out_valid, busy}, 2'b00);

        // gap of 3 idle cycles between products
        expect_result(32'd1024, 1'b0, 24'd1024, 1'b0);
        do_start(2);
        send_prod(1000);
        for (int i = 0; i < 3; i++) begin
            chk("gap_hold_acc", acc_out, 32'd1000);
            chk("gap_no_valid", {out_valid, in_ready}, 2'b01);
            tick();
        end
        send_prod(24);
        chk("gap_done", {out_valid, acc_out}, {1'b1, 32'd1024});
        tick();

        // saturation: 3 x 4194304 overflows 24 bits but not 32 bits
        expect_result(32'd12582912, 1'b0, 24'd8388607, 1'b1);
        do_start(3);
        in_valid = 1'b1;
        set_prod(4194304);
        tick();
        tick();
        chk("sat_ovf24_mid", ovf24, 1);
        chk("sat_ovf32_mid", ovf, 0);
        tick();
        in_valid = 1'b0;
        chk("sat_acc24", acc_out24, 24'd8388607);
        tick();

        // backpressure in DONE, start ignored, then start on exit cycle ignored
        expect_result(32'd7, 1'b0, 24'd7, 1'b0);
        do_start(2);
        out_ready = 1'b0;
        send_prod(3);
        send_prod(4);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_acc", acc_out, 32'd7);
            start = 1'b1;
            len   = 8'd5;
            tick();
        end
        chk("hold_still_done", {out_valid, busy, ovf}, 3'b110);
        expect_result(32'd0, 1'b0, 24'd0, 1'b0);
        out_ready = 1'b1;
        len       = 8'd0;
        tick();
        chk("exit_idle", {out_valid, busy}, 2'b00);
        chk("exit_keeps_acc", acc_out, 32'd7);
        tick();
        start = 1'b0;
        chk("len0_valid", out_valid, 1);
        chk("len0_result", {ovf, acc_out}, 33'd0);
        tick();

        // reset mid-operation: abandoned, nothing emitted
        do_start(4);
        in_valid = 1'b1;
        set_prod(10);
        tick();
        set_prod(20);
        tick();
        chk("rst_pre_acc", acc_out, 32'd30);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_acc", acc_out, 0);
        chk("rst_async_flags", {ovf, out_valid, in_ready, busy, dbg_state}, 0);
        chk("rst_async_24", {acc_out24, out_valid24, busy24}, 0);
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        expect_result(32'hFFFF_FFFB, 1'b0, 24'hFF_FFFB, 1'b0);
        do_start(1);
        send_prod(-5);
        chk("post_rst_value", {out_valid, acc_out}, {1'b1, 32'hFFFF_FFFB});
        tick();

        // maximum count, no wrap
        expect_result(32'd255, 1'b0, 24'd255, 1'b0);
        do_start(255);
        in_valid = 1'b1;
        set_prod(1);
        for (int i = 0; i < 254; i++) begin
            tick();
        end
        chk("len255_not_done", {out_valid, acc_out}, {1'b0, 32'd254});
        tick();
        in_valid = 1'b0;
        chk("len255_done", {out_valid, acc_out}, {1'b1, 32'd255});
        tick();

        // drain scoreboard with a bounded wait
        for (int i = 0; i < 20 && (exp_q.size() != 0 || exp24_q.size() != 0); i++) begin
            tick();
        end
        checks++;
        if (exp_q.size() != 0 || exp24_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending32=%0d pending24=%0d expected=0", exp_q.size(), exp24_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac_accum.md
MAC_ACCUM -- requirements
Module: mac_accum

Interface
REQ-001 SHALL have parameter WIDTH, default 12: operand width of the upstream radix-4 Booth multiplier; even only.
REQ-002 SHALL have parameter ACC_W, default 32: accumulator width; ACC_W >= 2*WIDTH.
REQ-003 SHALL have parameter LEN_W, default 8: width of the product-count field.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port start, input, 1 bit: begin a dot product; sampled in IDLE only.
REQ-007 SHALL have port len, input, LEN_W bits: number of products to accumulate; sampled with start.
REQ-008 SHALL have port prod, input, 2*WIDTH bits: signed product from the Booth multiplier.
REQ-009 SHALL have port in_valid, input, 1 bit: prod is valid.
REQ-010 SHALL have port in_ready, output, 1 bit: block accepts prod this cycle.
REQ-011 SHALL have port acc_out, output, ACC_W bits: signed accumulated result.
REQ-012 SHALL have port ovf, output, 1 bit: saturation occurred during this dot product.
REQ-013 SHALL have port out_valid, output, 1 bit: acc_out and ovf hold a result.
REQ-014 SHALL have port out_ready, input, 1 bit: downstream takes the result.
REQ-015 SHALL have port busy, output, 1 bit: state is not IDLE.

Function
REQ-016 SHALL implement the FSM states IDLE, ACC and DONE.
REQ-017 SHALL, in IDLE on start with len != 0, clear the accumulator and ovf, load the count register with len and go to ACC.
REQ-018 SHALL, in IDLE on start with len == 0, clear the accumulator and ovf and go directly to DONE, giving result 0.
REQ-019 SHALL drive in_ready = 1 only in ACC; a transfer occurs when in_valid && in_ready.
REQ-020 SHALL, on each transfer, sign-extend prod to ACC_W+1 bits, add it to the sign-extended accumulator and saturate to the signed ACC_W range (max 2^(ACC_W-1)-1, min -2^(ACC_W-1)).
REQ-021 SHALL set ovf, sticky until the next start, whenever the saturation in REQ-020 clamps the sum.
REQ-022 SHALL decrement the count on each transfer and go to DONE on the transfer where the count equals 1.
REQ-023 SHALL, in ACC with in_valid = 0, hold the accumulator and count unchanged.
REQ-024 SHALL assert out_valid exactly when in DONE, i.e. the cycle after the last transfer (latency 1).
REQ-025 SHALL hold acc_out and ovf stable while out_valid = 1 and out_ready = 0.
REQ-026 SHALL, in DONE with out_ready = 1, return to IDLE; acc_out keeps its value, out_valid drops.
REQ-027 SHALL ignore start in ACC and DONE.
REQ-028 SHALL, when start arrives in the same cycle as the DONE -> IDLE transition, ignore it; start is honoured the following cycle.
REQ-029 SHALL treat len = 2^LEN_W - 1 as a valid count, with no wrap of the count register.

Reset
REQ-030 SHALL, while rst_n = 0, immediately force state IDLE, acc_out = 0, ovf = 0, count = 0, out_valid = 0, in_ready = 0 and busy = 0.
REQ-031 SHALL abandon any dot product in progress on reset mid-operation, with no result emitted.

Structure
REQ-032 SHALL place WIDTH, ACC_W and LEN_W defaults and the state encoding (IDLE = 2'd0, ACC = 2'd1, DONE = 2'd2) in shared package mac_pkg.
REQ-033 SHALL implement the saturating adder as one combinational sub-module, sat_add, with outputs sum and clamp.
REQ-034 SHALL keep all registers in mac_accum.

Verification
REQ-035 SHALL pass: len = 3, prods 100, -50, 7 with in_valid held high -> out_valid on the 4th cycle after start, acc_out = 57, ovf = 0.
REQ-036 SHALL pass: len = 2, prods 1000, 24 with a 3-cycle in_valid gap between them -> acc_out = 1024; accumulator unchanged during the gap.
REQ-037 SHALL pass, with ACC_W = 24: len = 3, each prod = 4194304 (-2048 * -2048) -> acc_out = 8388607, ovf = 1.
REQ-038 SHALL pass: len = 0 on start -> out_valid the next cycle, acc_out = 0, ovf = 0.
REQ-039 SHALL pass: out_ready = 0 for 5 cycles in DONE -> acc_out stable, start ignored; out_ready = 1 -> IDLE the next cycle.
REQ-040 SHALL pass: rst_n = 0 pulse after 2 of 4 products -> all outputs 0 immediately; a new start with len = 1, prod = -5 -> acc_out = -5.
